norm_param_sequencer: RTL and testbench

//  Control/sequencing block for the per-row normalization datapath (norm) behind the matmul output.

---
 rtl/norm_param_sequencer.sv | 169 ++++++++++++++++
 tb/tb_norm_param_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/norm_param_sequencer.sv
// rtl/norm_param_sequencer.sv - per-tile (mean, inv_var) sequencer for the norm unit behind matmul
// Loads table entries at tile boundaries, gates row strobes into norm, pulses done after drain.
module norm_param_sequencer #(
  parameter int DWIDTH       = 8,
  parameter int NUM_ENTRIES  = 8,
  parameter int AW           = 3,
  parameter int CNT_W        = 8,
  parameter int NORM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [DWIDTH-1:0] cfg_mean,
  input  logic [DWIDTH-1:0] cfg_inv_var,
  input  logic              start,
  input  logic              abort,
  input  logic [AW:0]       num_tiles,
  input  logic [CNT_W-1:0]  rows_per_tile,
  input  logic              mm_data_available,
  output logic              enable_norm,
  output logic              norm_in_available,
  output logic [DWIDTH-1:0] mean,
  output logic [DWIDTH-1:0] inv_var,
  output logic              busy,
  output logic              done,
  output logic              beat_dropped
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam int DCW = (NORM_LATENCY > 1) ? $clog2(NORM_LATENCY) : 1;

  state_t            state, next_state;
  logic [DWIDTH-1:0] tbl_mean    [NUM_ENTRIES];
  logic [DWIDTH-1:0] tbl_inv_var [NUM_ENTRIES];
  logic [AW:0]       tiles_lat;
  logic [CNT_W-1:0]  rows_lat;
  logic [CNT_W-1:0]  row_cnt;
  logic [AW-1:0]     tile_idx;
  logic [AW-1:0]     next_tile;
  logic [DCW-1:0]    drain_cnt;
  logic              addr_ok;
  logic              start_ok;
  logic              last_row;
  logic              last_tile;
  logic              drain_last;

  // With a power-of-two table every encodable address is in range.
  generate
    if (NUM_ENTRIES < (1 << AW)) begin : g_addr_chk
      assign addr_ok = (cfg_addr < AW'(NUM_ENTRIES));
    end else begin : g_addr_full
      assign addr_ok = 1'b1;
    end
  endgenerate

  assign start_ok   = (num_tiles != '0) && (num_tiles <= (AW+1)'(NUM_ENTRIES)) &&
                      (rows_per_tile != '0);
  assign last_row   = (row_cnt == rows_lat - 1'b1);
  assign last_tile  = ({1'b0, tile_idx} == tiles_lat - 1'b1);
  assign next_tile  = tile_idx + 1'b1;
  assign drain_last = (drain_cnt == DCW'(NORM_LATENCY - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) next_state = start_ok ? S_RUN : S_DONE;
        S_RUN:   if (mm_data_available && last_row && last_tile) next_state = S_DRAIN;
        S_DRAIN: if (drain_last) next_state = S_DONE;
        default: next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    enable_norm       = (state == S_RUN) || (state == S_DRAIN);
    busy              = (state == S_RUN) || (state == S_DRAIN);
    norm_in_available = (state == S_RUN) && mm_data_available;
    done              = (state == S_DONE);
  end

  // Table writes use non-blocking assignment, so a same-edge load sees the old entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        tbl_mean[i]    <= '0;
        tbl_inv_var[i] <= '0;
      end
    end else if (cfg_we && addr_ok) begin
      tbl_mean[cfg_addr]    <= cfg_mean;
      tbl_inv_var[cfg_addr] <= cfg_inv_var;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tiles_lat <= '0;
      rows_lat  <= '0;
      row_cnt   <= '0;
      tile_idx  <= '0;
      drain_cnt <= '0;
      mean      <= '0;
      inv_var   <= '0;
    end else if (abort) begin
      row_cnt   <= '0;
      tile_idx  <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && start_ok) begin
            tiles_lat <= num_tiles;
            rows_lat  <= rows_per_tile;
            row_cnt   <= '0;
            tile_idx  <= '0;
            drain_cnt <= '0;
            mean      <= tbl_mean[0];
            inv_var   <= tbl_inv_var[0];
          end
        end
        S_RUN: begin
          if (mm_data_available) begin
            if (last_row) begin
              row_cnt <= '0;
              // Final tile keeps its parameters through the drain.
              if (!last_tile) begin
                tile_idx <= next_tile;
                mean     <= tbl_mean[next_tile];
                inv_var  <= tbl_inv_var[next_tile];
              end
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        S_DRAIN: drain_cnt <= drain_cnt + 1'b1;
        default: begin
          drain_cnt <= '0;
          row_cnt   <= '0;
          tile_idx  <= '0;
        end
      endcase
    end
  end

  // A dropped beat in the same cycle as an accepted start still records the drop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      beat_dropped <= 1'b0;
    end else if (mm_data_available && (state != S_RUN)) begin
      beat_dropped <= 1'b1;
    end else if ((state == S_IDLE) && start && start_ok && !abort) begin
      beat_dropped <= 1'b0;
    end
  end

endmodule

// File: tb/tb_norm_param_sequencer.sv
// tb/tb_norm_param_sequencer.sv - scoreboard bench for norm_param_sequencer
// Expected params come from a table snapshot indexed by beat_number / rows_per_tile.
module tb_norm_param_sequencer;

  logic       clk = 1'b0;
  logic       resetn;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_mean;
  logic [7:0] cfg_inv_var;
  logic       start;
  logic       abort;
  logic [3:0] num_tiles;
  logic [7:0] rows_per_tile;
  logic       mm_data_available;
  logic       enable_norm;
  logic       norm_in_available;
  logic [7:0] mean;
  logic [7:0] inv_var;
  logic       busy;
  logic       done;
  logic       beat_dropped;

  norm_param_sequencer dut (
    .clk(clk), .resetn(resetn), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_mean(cfg_mean), .cfg_inv_var(cfg_inv_var), .start(start), .abort(abort),
    .num_tiles(num_tiles), .rows_per_tile(rows_per_tile),
    .mm_data_available(mm_data_available), .enable_norm(enable_norm),
    .norm_in_available(norm_in_available), .mean(mean), .inv_var(inv_var),
    .busy(busy), .done(done), .beat_dropped(beat_dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] m;
    logic [7:0] v;
  } par_t;

  par_t       exp_q[$];
  int         done_q[$];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic [7:0] tm[8];
  logic [7:0] tv[8];
  par_t       mon_p;
  int         mon_c;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      if (norm_in_available) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          mon_p = exp_q.pop_front();
          check("beat_mean", mean, mon_p.m);
          check("beat_inv_var", inv_var, mon_p.v);
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          mon_c = done_q.pop_front();
          check("done_cycle", cyc, mon_c);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int a, input int m, input int v);
    cfg_we = 1'b1; cfg_addr = 3'(a); cfg_mean = 8'(m); cfg_inv_var = 8'(v);
    if (a < 8) begin
      tm[a] = 8'(m);
      tv[a] = 8'(v);
    end
    tick;
    cfg_we = 1'b0;
  endtask

  task automatic wait_done;
    int t = 0;
    while (done_q.size() != 0 && t < 50) begin
      tick;
      t++;
    end
    check("done_timeout", done_q.size(), 0);
    check("beats_left", exp_q.size(), 0);
    tick;
    check("idle_busy", busy, 0);
  endtask

  task automatic run_job(input int tiles, input int rows, input int gap_max, input bit wr0);
    logic [7:0] sm[8];
    logic [7:0] sv[8];
    bit ok;
    int total;
    for (int i = 0; i < 8; i++) begin
      sm[i] = tm[i];
      sv[i] = tv[i];
    end
    ok = (tiles >= 1) && (tiles <= 8) && (rows != 0);
    start = 1'b1; num_tiles = 4'(tiles); rows_per_tile = 8'(rows);
    if (!ok) done_q.push_back(cyc + 1);
    tick;
    start = 1'b0;
    if (!ok) begin
      check("invalid_enable", enable_norm, 0);
      tick;
      check("invalid_enable_after", enable_norm, 0);
      wait_done;
      return;
    end
    check("run_enable", enable_norm, 1);
    check("run_busy", busy, 1);
    check("start_clears_drop", beat_dropped, 0);
    total = tiles * rows;
    for (int k = 0; k < total; k++) begin
      mm_data_available = 1'b0;
      repeat ($urandom_range(0, gap_max)) tick;
      mm_data_available = 1'b1;
      exp_q.push_back('{sm[k / rows], sv[k / rows]});
      if (k == total - 1) done_q.push_back(cyc + 2);
      tick;
      mm_data_available = 1'b0;
      if (k == total - 1) begin
        check("drain_enable", enable_norm, 1);
        check("drain_gate", norm_in_available, 0);
      end
      if (wr0 && k == 0) cfg_write(0, $urandom_range(100, 255), $urandom_range(100, 255));
    end
    wait_done;
  endtask

  initial begin
    resetn = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_mean = '0; cfg_inv_var = '0;
    start = 1'b0; abort = 1'b0; num_tiles = '0; rows_per_tile = '0;
    mm_data_available = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tm[i] = '0;
      tv[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_mean", mean, 0);
    check("rst_inv_var", inv_var, 0);
    check("rst_enable", enable_norm, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_drop", beat_dropped, 0);
    check("rst_gate", norm_in_available, 0);
    @(negedge clk);
    resetn = 1'b1;
    tick;

    run_job(1, 1, 0, 0);
    cfg_write(0, 10, 2);
    cfg_write(1, 20, 3);
    run_job(2, 3, 0, 0);
    run_job(2, 3, 3, 0);
    run_job(0, 3, 0, 0);
    run_job(2, 0, 0, 0);
    run_job(12, 2, 0, 0);

    mm_data_available = 1'b1;
    #1;
    check("idle_beat_gate", norm_in_available, 0);
    tick;
    mm_data_available = 1'b0;
    check("idle_beat_dropped", beat_dropped, 1);
    run_job(1, 2, 0, 0);

    // Abort at tile 1 row 1: no done, and the drop flag is left alone.
    start = 1'b1; num_tiles = 4'd2; rows_per_tile = 8'd3;
    tick;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mm_data_available = 1'b1;
      exp_q.push_back('{tm[k / 3], tv[k / 3]});
      tick;
    end
    mm_data_available = 1'b0;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_enable", enable_norm, 0);
    check("abort_done", done, 0);
    repeat (4) tick;
    check("abort_beats_left", exp_q.size(), 0);

    // Reset mid-run clears everything at once, table included.
    start = 1'b1; num_tiles = 4'd2; rows_per_tile = 8'd3;
    tick;
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mm_data_available = 1'b1;
      exp_q.push_back('{tm[0], tv[0]});
      tick;
    end
    mm_data_available = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check("midrst_mean", mean, 0);
    check("midrst_inv_var", inv_var, 0);
    check("midrst_enable", enable_norm, 0);
    check("midrst_busy", busy, 0);
    for (int i = 0; i < 8; i++) begin
      tm[i] = '0;
      tv[i] = '0;
    end
    @(negedge clk);
    resetn = 1'b1;
    tick;

    cfg_write(0, 10, 2);
    cfg_write(1, 20, 3);
    run_job(2, 3, 1, 1);
    run_job(1, 2, 0, 0);

    for (int j = 0; j < 12; j++) begin
      int tiles;
      int rows;
      repeat ($urandom_range(0, 3)) cfg_write($urandom_range(0, 7), $urandom_range(0, 255),
                                               $urandom_range(0, 255));
      tiles = $urandom_range(1, 8);
      rows  = $urandom_range(1, 4);
      if ($urandom_range(0, 7) == 0) tiles = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(9, 15);
      if ($urandom_range(0, 9) == 0) rows = 0;
      run_job(tiles, rows, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    check("final_beats_left", exp_q.size(), 0);
    check("final_done_left", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
